// File: rtl/seg_pkg.sv
// seg_pkg: scan FSM states, digit count and active-low CA..CG glyph table for 0..F
package seg_pkg;
  typedef enum logic {BLANK, SHOW} state_t;
  localparam int N_DIGITS = 4;
  localparam logic [6:0] SEG_LUT [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };
endpackage

// File: rtl/seg_hex_decoder.sv
// seg_hex_decoder: combinational hex nibble val -> active-low segments seg {CA..CG}
module seg_hex_decoder
  import seg_pkg::*;
(
  input  logic [3:0] val,
  output logic [6:0] seg
);
  assign seg = SEG_LUT[val];
endmodule

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: 4-digit 7-seg scanner; i_w_clk/i_w_reset, i_w_wr_* shadow write port, o_r_AN0..3/CA..CG/DP active-low, o_r_frame_tick on commit; SEG_LEADING_ZERO_BLANK_EN darkens leading zeros
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int P_DIV   = 50000,
  parameter int P_GUARD = 500
) (
  input  logic       i_w_clk,
  input  logic       i_w_reset,
  input  logic       i_w_wr_en,
  input  logic [1:0] i_w_wr_idx,
  input  logic [3:0] i_w_wr_val,
  input  logic       i_w_wr_dp,
  output logic       o_r_AN0,
  output logic       o_r_AN1,
  output logic       o_r_AN2,
  output logic       o_r_AN3,
  output logic       o_r_CA,
  output logic       o_r_CB,
  output logic       o_r_CC,
  output logic       o_r_CD,
  output logic       o_r_CE,
  output logic       o_r_CF,
  output logic       o_r_CG,
  output logic       o_r_DP,
  output logic       o_r_frame_tick
);
  localparam int CW = $clog2((P_DIV > P_GUARD ? P_DIV : P_GUARD) + 1);
  state_t state, nstate;
  logic [CW-1:0] cnt;
  logic [1:0] idx, nidx;
  logic [N_DIGITS-1:0][3:0] sh_val, act_val, nx_val;
  logic [N_DIGITS-1:0] sh_dp, act_dp, nx_dp;
  logic done, commit, lz;
  logic [3:0] dval;
  logic [6:0] dseg;
  logic [3:0] an;
  logic [6:0] seg;
  logic dp, tick;
  always_comb begin
    done   = state == SHOW ? cnt == CW'(P_DIV - 1) : (P_GUARD == 0 || cnt == CW'(P_GUARD - 1));
    nstate = done ? ((state == SHOW && P_GUARD != 0) ? BLANK : SHOW) : state;
    nidx   = (done && state == SHOW) ? idx + 2'd1 : idx;
    commit = done && nstate == SHOW && nidx == 2'd0;
    nx_val = commit ? sh_val : act_val;
    nx_dp  = commit ? sh_dp : act_dp;
    dval   = nx_val[nidx];
  end
`ifdef SEG_LEADING_ZERO_BLANK_EN
  always_comb begin
    lz = nidx != 2'd0;
    for (int j = 1; j < N_DIGITS; j++) if (j >= int'(nidx) && nx_val[j] != 4'd0) lz = 1'b0;
  end
`else
  assign lz = 1'b0;
`endif
  seg_hex_decoder u_dec (.val(dval), .seg(dseg));
  always_ff @(posedge i_w_clk) begin
    if (i_w_reset) begin
      state   <= BLANK;
      cnt     <= '0;
      idx     <= '0;
      sh_val  <= '0;
      sh_dp   <= '0;
      act_val <= '0;
      act_dp  <= '0;
      an      <= '1;
      seg     <= '1;
      dp      <= 1'b1;
      tick    <= 1'b0;
    end else begin
      state <= nstate;
      cnt   <= done ? '0 : cnt + 1'b1;
      idx   <= nidx;
      if (i_w_wr_en) begin
        sh_val[i_w_wr_idx] <= i_w_wr_val;
        sh_dp[i_w_wr_idx]  <= i_w_wr_dp;
      end
      if (commit) begin
        act_val <= sh_val;
        act_dp  <= sh_dp;
      end
      an   <= nstate == SHOW ? ~(4'd1 << nidx) : '1;
      seg  <= nstate == SHOW && !lz ? dseg : '1;
      dp   <= nstate == SHOW ? ~nx_dp[nidx] : 1'b1;
      tick <= commit;
    end
  end
  assign {o_r_AN3, o_r_AN2, o_r_AN1, o_r_AN0} = an;
  assign {o_r_CA, o_r_CB, o_r_CC, o_r_CD, o_r_CE, o_r_CF, o_r_CG} = seg;
  assign o_r_DP = dp;
  assign o_r_frame_tick = tick;
endmodule
